// File: rtl/data_mem_axil_slave.sv
// AXI4-Lite slave in front of a single-port synchronous word RAM.
// One transaction in flight; writes win over reads arriving together.
module data_mem_axil_slave #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              s_aclk,
    input  logic              s_aresetn,
    input  logic [31:0]       s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [31:0]       s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned DW     = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LSB    = 2;
    localparam int unsigned MSB    = MEM_AW + LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        BRESP,
        RD,
        RDRESP
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_q;
    logic                aw_cap_q, aw_cap_d;
    logic                w_cap_q, w_cap_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                ram_en_q, ram_en_d;
    logic [STRB_W-1:0]   ram_we_q, ram_we_d;
    logic [MEM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]       ram_wdata_q, ram_wdata_d;

    logic                idle_open;
    logic                aw_hs, w_hs, ar_hs;
    logic                aw_err, ar_err;
    logic                addr_lsb_unused;

    // Any address bit above the RAM window makes the access an error.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-1:MSB];
    endfunction

    // Byte-offset bits carry no meaning for a word RAM.
    assign addr_lsb_unused = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    // Ready/handshake decode; rdy_q holds readies low until the first edge out of reset.
    assign idle_open     = rdy_q && (state_q == IDLE);
    assign s_axi_awready = idle_open && !aw_cap_q;
    assign s_axi_wready  = idle_open && !w_cap_q;
    assign s_axi_arready = idle_open && !aw_cap_q && !w_cap_q &&
                           !s_axi_awvalid && !s_axi_wvalid;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign aw_err = addr_err(s_axi_awaddr);
    assign ar_err = addr_err(s_axi_araddr);

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;

    // State, capture and output registers.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            aw_cap_q    <= 1'b0;
            w_cap_q     <= 1'b0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            aw_cap_q    <= aw_cap_d;
            w_cap_q     <= w_cap_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Next-state and registered-output logic; RAM strobes are single-cycle pulses.
    always_comb begin
        state_d     = state_q;
        aw_cap_d    = aw_cap_q;
        w_cap_d     = w_cap_q;
        addr_d      = addr_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = '0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    aw_cap_d = 1'b1;
                    addr_d   = s_axi_awaddr[MSB-1:LSB];
                    err_d    = aw_err;
                end
                if (w_hs) begin
                    w_cap_d = 1'b1;
                    wdata_d = s_axi_wdata;
                    wstrb_d = s_axi_wstrb;
                end
                if (aw_cap_q && w_cap_q) begin
                    state_d     = WR;
                    ram_en_d    = !err_q;
                    ram_we_d    = err_q ? STRB_W'(0) : wstrb_q;
                    ram_addr_d  = addr_q;
                    ram_wdata_d = wdata_q;
                end else if (ar_hs) begin
                    state_d    = RD;
                    ram_en_d   = !ar_err;
                    ram_addr_d = s_axi_araddr[MSB-1:LSB];
                    err_d      = ar_err;
                end
            end
            WR: begin
                state_d  = BRESP;
                bvalid_d = 1'b1;
                bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            BRESP: begin
                if (s_axi_bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                    aw_cap_d = 1'b0;
                    w_cap_d  = 1'b0;
                end
            end
            RD: begin
                state_d = RDRESP;
            end
            RDRESP: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = err_q ? DW'(0) : ram_rdata;
                    rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                end else if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
